// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM_IF memory port among COUNT requesters
module ram_arbiter #(
   parameter int COUNT          = 4,
   parameter int ADDR_BIT_WIDTH = 24,
   parameter int RFSH_PRIORITY  = 1
) (
   input  logic                            CLK_i,
   input  logic                            RESET_n_i,
   input  logic [COUNT*ADDR_BIT_WIDTH-1:0] REQ_ADDR_i,
   input  logic [COUNT*32-1:0]             REQ_DIN_i,
   input  logic [COUNT*2-1:0]              REQ_DIN_SIZE_i,
   input  logic [COUNT-1:0]                REQ_OE_n_i,
   input  logic [COUNT-1:0]                REQ_WE_n_i,
   input  logic [COUNT-1:0]                REQ_RFSH_n_i,
   output logic [31:0]                     REQ_DOUT_o,
   output logic [COUNT-1:0]                REQ_ACK_n_o,
   output logic [COUNT-1:0]                REQ_TIMING_o,
   output logic [ADDR_BIT_WIDTH-1:0]       M_ADDR_o,
   output logic [31:0]                     M_DIN_o,
   output logic [1:0]                      M_DIN_SIZE_o,
   output logic                            M_OE_n_o,
   output logic                            M_WE_n_o,
   output logic                            M_RFSH_n_o,
   input  logic [31:0]                     M_DOUT_i,
   input  logic                            M_ACK_n_i,
   input  logic                            M_TIMING_i
);
   localparam int         PW         = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [1:0] DIN_SIZE_8 = 2'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

   state_e                    state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [PW-1:0]             grant_q, grant_d;
   logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               din_q, din_d;
   logic [31:0]               dout_q, dout_d;
   logic [1:0]                size_q, size_d;
   logic [2:0]                stb_q, stb_d;     // {rfsh_n, we_n, oe_n}
   logic [COUNT-1:0]          ack_n_q, ack_n_d;

   logic [COUNT-1:0]          pend;
   logic [COUNT-1:0]          rfsh_pend;
   logic [PW:0]               pick_rfsh;
   logic [PW:0]               pick_any;
   logic [PW-1:0]             gsel;
   logic                      grant_released;

   // First set bit of mask at or after start, wrapping; MSB of the result flags "found".
   function automatic logic [PW:0] pick_from(input logic [COUNT-1:0] mask, input logic [PW-1:0] start);
      logic [PW:0] r;
      int          idx;
      r = '0;
      for (int k = COUNT - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= COUNT) idx = idx - COUNT;
         if (mask[PW'(idx)]) r = {1'b1, PW'(idx)};
      end
      return r;
   endfunction

   assign pend           = ~(REQ_OE_n_i & REQ_WE_n_i & REQ_RFSH_n_i);
   assign rfsh_pend      = ~REQ_RFSH_n_i;
   assign pick_rfsh      = pick_from(rfsh_pend, ptr_q);
   assign pick_any       = pick_from(pend, ptr_q);
   assign gsel           = ((RFSH_PRIORITY != 0) && pick_rfsh[PW]) ? pick_rfsh[PW-1:0] : pick_any[PW-1:0];
   assign grant_released = REQ_OE_n_i[grant_q] & REQ_WE_n_i[grant_q] & REQ_RFSH_n_i[grant_q];

   // State and registered port values; reset drops the memory command immediately.
   always_ff @(posedge CLK_i or negedge RESET_n_i) begin
      if (!RESET_n_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         size_q  <= DIN_SIZE_8;
         stb_q   <= 3'b111;
         dout_q  <= '0;
         ack_n_q <= '1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         size_q  <= size_d;
         stb_q   <= stb_d;
         dout_q  <= dout_d;
         ack_n_q <= ack_n_d;
      end
   end

   // Next state: grant on any request, finish on memory ack, re-arm once the grantee lets go.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pend)          state_d = BUSY;
         BUSY:    if (!M_ACK_n_i)     state_d = RELEASE;
         RELEASE: if (grant_released) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Next values of the memory command, returned data, ack pulse and round-robin pointer.
   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      din_d   = din_q;
      size_d  = size_q;
      stb_d   = stb_q;
      dout_d  = dout_q;
      ack_n_d = '1;
      case (state_q)
         IDLE: begin
            if (|pend) begin
               grant_d = gsel;
               addr_d  = REQ_ADDR_i[int'(gsel)*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH];
               din_d   = REQ_DIN_i[int'(gsel)*32 +: 32];
               size_d  = REQ_DIN_SIZE_i[int'(gsel)*2 +: 2];
               stb_d   = {REQ_RFSH_n_i[gsel], REQ_WE_n_i[gsel], REQ_OE_n_i[gsel]};
            end
         end
         BUSY: begin
            if (!M_ACK_n_i) begin
               stb_d            = 3'b111;
               dout_d           = M_DOUT_i;
               ack_n_d[grant_q] = 1'b0;
            end
         end
         RELEASE: begin
            if (grant_released) ptr_d = (grant_q == PW'(COUNT - 1)) ? '0 : grant_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign REQ_DOUT_o   = dout_q;
   assign REQ_ACK_n_o  = ack_n_q;
   assign REQ_TIMING_o = {COUNT{M_TIMING_i}};
   assign M_ADDR_o     = addr_q;
   assign M_DIN_o      = din_q;
   assign M_DIN_SIZE_o = size_q;
   assign M_OE_n_o     = stb_q[0];
   assign M_WE_n_o     = stb_q[1];
   assign M_RFSH_n_o   = stb_q[2];
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
   localparam int N    = 4;
   localparam int AW   = 24;
   localparam int RFSH = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]   addr [N];
   logic [31:0]     din  [N];
   logic [1:0]      size [N];
   logic [N-1:0]    oe_n = '1, we_n = '1, rf_n = '1;
   logic [N*AW-1:0] req_addr;
   logic [N*32-1:0] req_din;
   logic [N*2-1:0]  req_size;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_addr[gi*AW +: AW] = addr[gi];
      assign req_din[gi*32 +: 32]  = din[gi];
      assign req_size[gi*2 +: 2]   = size[gi];
   end

   logic [31:0]   dout, np_dout;
   logic [N-1:0]  ack_n, np_ack_n, timing, np_timing;
   logic [AW-1:0] m_addr, np_m_addr;
   logic [31:0]   m_din, np_m_din;
   logic [1:0]    m_size, np_m_size;
   logic          m_oe_n, m_we_n, m_rf_n, np_m_oe_n, np_m_we_n, np_m_rf_n;
   logic [31:0]   m_dout = '0;
   logic          m_ack_drv = 1'b1, spur = 1'b0, m_timing = 1'b0;
   logic          m_ack_n;
   assign m_ack_n = m_ack_drv & ~spur;

   ram_arbiter #(.COUNT(N), .ADDR_BIT_WIDTH(AW), .RFSH_PRIORITY(RFSH)) dut (
      .CLK_i(clk), .RESET_n_i(rst_n), .REQ_ADDR_i(req_addr), .REQ_DIN_i(req_din),
      .REQ_DIN_SIZE_i(req_size), .REQ_OE_n_i(oe_n), .REQ_WE_n_i(we_n), .REQ_RFSH_n_i(rf_n),
      .REQ_DOUT_o(dout), .REQ_ACK_n_o(ack_n), .REQ_TIMING_o(timing), .M_ADDR_o(m_addr),
      .M_DIN_o(m_din), .M_DIN_SIZE_o(m_size), .M_OE_n_o(m_oe_n), .M_WE_n_o(m_we_n),
      .M_RFSH_n_o(m_rf_n), .M_DOUT_i(m_dout), .M_ACK_n_i(m_ack_n), .M_TIMING_i(m_timing));

   ram_arbiter #(.COUNT(N), .ADDR_BIT_WIDTH(AW), .RFSH_PRIORITY(0)) dut_np (
      .CLK_i(clk), .RESET_n_i(rst_n), .REQ_ADDR_i(req_addr), .REQ_DIN_i(req_din),
      .REQ_DIN_SIZE_i(req_size), .REQ_OE_n_i(oe_n), .REQ_WE_n_i(we_n), .REQ_RFSH_n_i(rf_n),
      .REQ_DOUT_o(np_dout), .REQ_ACK_n_o(np_ack_n), .REQ_TIMING_o(np_timing), .M_ADDR_o(np_m_addr),
      .M_DIN_o(np_m_din), .M_DIN_SIZE_o(np_m_size), .M_OE_n_o(np_m_oe_n), .M_WE_n_o(np_m_we_n),
      .M_RFSH_n_o(np_m_rf_n), .M_DOUT_i(m_dout), .M_ACK_n_i(m_ack_n), .M_TIMING_i(m_timing));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int            m_out = -1;   // requester whose command is on the memory port
   int            m_rel = -1;   // requester served, waiting for it to drop strobes
   int            m_ptr = 0;
   int            mg;
   logic [AW-1:0] e_addr = '0;
   logic [31:0]   e_din = '0, e_dout = '0;
   logic [1:0]    e_size = '0;
   logic [2:0]    e_stb = 3'b111;
   logic [N-1:0]  e_ack = '1;
   int            glog[$];

   function automatic int choose();
      int best;
      int bestd;
      bit want_rf;
      best = -1; bestd = N; want_rf = 0;
      if (RFSH != 0) for (int i = 0; i < N; i++) if (!rf_n[i]) want_rf = 1;
      for (int i = 0; i < N; i++) begin
         bit p;
         int d;
         p = want_rf ? !rf_n[i] : !(oe_n[i] & we_n[i] & rf_n[i]);
         d = (i - m_ptr + N) % N;
         if (p && d < bestd) begin best = i; bestd = d; end
      end
      return best;
   endfunction

   function automatic int gat(input int i);
      return (i < glog.size()) ? glog[i] : -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out = -1; m_rel = -1; m_ptr = 0;
         e_addr = '0; e_din = '0; e_size = '0; e_stb = 3'b111; e_ack = '1; e_dout = '0;
         glog.delete();
      end else begin
         e_ack = '1;
         if (m_out >= 0) begin
            if (!m_ack_n) begin
               e_ack[m_out] = 1'b0;
               e_dout = m_dout;
               e_stb  = 3'b111;
               m_rel  = m_out;
               m_out  = -1;
            end
         end else if (m_rel >= 0) begin
            if (oe_n[m_rel] & we_n[m_rel] & rf_n[m_rel]) begin
               m_ptr = (m_rel + 1) % N;
               m_rel = -1;
            end
         end else begin
            mg = choose();
            if (mg >= 0) begin
               m_out  = mg;
               e_addr = addr[mg];
               e_din  = din[mg];
               e_size = size[mg];
               e_stb  = {rf_n[mg], we_n[mg], oe_n[mg]};
               glog.push_back(mg);
            end
         end
      end
   end

   // ---------------- compare process ----------------
   int       cyc = 0;
   logic [2:0] stb_now, stb_prev = 3'b111;
   int       cmd_cyc[$];
   int       ack_cyc[$];

   always @(negedge clk) begin
      cyc++;
      stb_now = {m_rf_n, m_we_n, m_oe_n};
      if (!rst_n) begin
         cmd_cyc.delete();
         ack_cyc.delete();
      end else begin
         chk("m_addr", m_addr, e_addr);
         chk("m_din", m_din, e_din);
         chk("m_size", m_size, e_size);
         chk("m_strobes", stb_now, e_stb);
         chk("req_ack_n", ack_n, e_ack);
         chk("req_dout", dout, e_dout);
         chk("req_timing", timing, {N{m_timing}});
         if (stb_prev == 3'b111 && stb_now != 3'b111) cmd_cyc.push_back(cyc);
         if (ack_n != '1) ack_cyc.push_back(cyc);
      end
      stb_prev = stb_now;
   end

   // ---------------- memory responder ----------------
   int          mem_lat = 3;
   logic [31:0] mem_data = '0;
   int          mcnt = 0;
   bit          served = 0;

   always @(posedge clk) begin
      #1;
      m_ack_drv = 1'b1;
      m_timing  = 1'($urandom_range(0, 1));
      if (!rst_n || (m_oe_n & m_we_n & m_rf_n)) begin
         mcnt = 0;
         served = 0;
      end else if (!served) begin
         mcnt++;
         if (mcnt >= mem_lat) begin
            m_ack_drv = 1'b0;
            m_dout    = mem_data;
            served    = 1;
         end
      end
   end

   // ---------------- requesters drop strobes after their ack ----------------
   int hold[N];
   int rel_cnt[N];

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rel_cnt[i] > 0) begin
            rel_cnt[i]--;
            if (rel_cnt[i] == 0) begin oe_n[i] = 1'b1; we_n[i] = 1'b1; rf_n[i] = 1'b1; end
         end else if (rst_n && !ack_n[i]) begin
            if (hold[i] == 0) begin oe_n[i] = 1'b1; we_n[i] = 1'b1; rf_n[i] = 1'b1; end
            else rel_cnt[i] = hold[i];
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      oe_n = '1; we_n = '1; rf_n = '1;
      for (int i = 0; i < N; i++) rel_cnt[i] = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_done();
      int  n;
      bit  quiet;
      n = 0;
      quiet = 0;
      while (!quiet && n < 200) begin
         @(negedge clk);
         n++;
         quiet = (oe_n == '1) && (we_n == '1) && (rf_n == '1);
         for (int i = 0; i < N; i++) if (rel_cnt[i] != 0) quiet = 0;
      end
      chk("wait_done", quiet, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      addr[0] = 24'hA00010; addr[1] = 24'h012345; addr[2] = 24'hB20020; addr[3] = 24'hC30030;
      din[0]  = 32'hC0DE0000; din[1] = 32'hC0DE1111; din[2] = 32'hC0DE2222; din[3] = 32'hC0DE3333;
      size[0] = 2'd0; size[1] = 2'd1; size[2] = 2'd2; size[3] = 2'd1;

      // reset state
      do_reset();
      chk("rst_m_addr", m_addr, 24'h0);
      chk("rst_m_din", m_din, 32'h0);
      chk("rst_m_size", m_size, 2'd0);
      chk("rst_strobes", {m_rf_n, m_we_n, m_oe_n}, 3'b111);
      chk("rst_ack", ack_n, 4'hF);
      chk("rst_dout", dout, 32'h0);

      // single read by requester 1
      mem_data = 32'hDEADBEEF;
      @(negedge clk); oe_n[1] = 1'b0;
      @(negedge clk);
      chk("t1_m_addr", m_addr, 24'h012345);
      chk("t1_m_oe", m_oe_n, 1'b0);
      n = 0;
      while (ack_n == '1 && n < 50) begin @(negedge clk); n++; end
      chk("t1_ack", ack_n, 4'b1101);
      chk("t1_dout", dout, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_ack_pulse", ack_n, 4'hF);
      wait_done();
      chk("t1_latency", (ack_cyc.size() > 0 && cmd_cyc.size() > 0) ? ack_cyc[0] - cmd_cyc[0] + 1 : -1, 4);

      // spurious memory ack while idle
      @(negedge clk); m_dout = 32'h0BADF00D; spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      @(negedge clk);
      chk("t6_ack", ack_n, 4'hF);
      chk("t6_dout", dout, 32'hDEADBEEF);
      chk("t6_strobes", {m_rf_n, m_we_n, m_oe_n}, 3'b111);

      // round-robin among three writers, then pointer back at 0
      do_reset();
      mem_data = 32'h22224444;
      @(negedge clk); we_n[0] = 1'b0; we_n[2] = 1'b0; we_n[3] = 1'b0;
      wait_done();
      chk("t2_count", glog.size(), 3);
      chk("t2_g0", gat(0), 0);
      chk("t2_g1", gat(1), 2);
      chk("t2_g2", gat(2), 3);
      @(negedge clk); oe_n[1] = 1'b0; oe_n[3] = 1'b0;
      wait_done();
      chk("t2_ptr_wrap_g3", gat(3), 1);
      chk("t2_ptr_wrap_g4", gat(4), 3);

      // refresh priority vs plain round-robin
      do_reset();
      @(negedge clk); oe_n[0] = 1'b0; rf_n[3] = 1'b0;
      @(negedge clk);
      chk("t3_rfsh_addr", m_addr, 24'hC30030);
      chk("t3_rfsh_strobe", m_rf_n, 1'b0);
      chk("t3_np_addr", np_m_addr, 24'hA00010);
      chk("t3_np_oe", np_m_oe_n, 1'b0);
      wait_done();
      chk("t3_count", glog.size(), 2);
      chk("t3_g0", gat(0), 3);
      chk("t3_g1", gat(1), 0);

      // grantee holds its read after the ack; requester 1 must wait
      do_reset();
      hold[2] = 5;
      @(negedge clk); oe_n[2] = 1'b0;
      @(negedge clk); oe_n[1] = 1'b0;
      wait_done();
      hold[2] = 0;
      chk("t4_count", glog.size(), 2);
      chk("t4_g0", gat(0), 2);
      chk("t4_g1", gat(1), 1);
      chk("t4_gap", (ack_cyc.size() > 0 && cmd_cyc.size() > 1) ? cmd_cyc[1] - ack_cyc[0] : -1, 7);

      // reset in the middle of a write
      do_reset();
      @(negedge clk); oe_n[2] = 1'b0;
      wait_done();
      mem_lat = 20;
      @(negedge clk); we_n[0] = 1'b0;
      n = 0;
      while (m_we_n && n < 10) begin @(negedge clk); n++; end
      chk("t5_busy", m_we_n, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_we", m_we_n, 1'b1);
      chk("t5_rst_ack", ack_n, 4'hF);
      chk("t5_rst_addr", m_addr, 24'h0);
      we_n[0] = 1'b1;
      @(negedge clk); rst_n = 1'b1; mem_lat = 3;
      @(negedge clk); oe_n[1] = 1'b0; oe_n[3] = 1'b0;
      wait_done();
      chk("t5_count", glog.size(), 2);
      chk("t5_g0", gat(0), 1);
      chk("t5_g1", gat(1), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
